// File: rtl/seg_scan_controller.sv
// Prescaled scan sequencer for a 4-digit common-anode seven-segment display.
// Drives one digit per slot with a blanking guard and commits new values only at frame boundaries.
module seg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_suppress,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]    digit_r, digit_nxt_s;
  logic          frame_end_s;
  logic [15:0]   active_val_r, pend_val_r;
  logic [3:0]    active_dp_r, pend_dp_r;
  logic          pend_flag_r;
  logic [3:0]    nibble_s;
  logic          upper_zero_s;
  logic          lit_s;

  // Active-low {g,f,e,d,c,b,a} hex glyphs
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      4'hF:    hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  // Scan state, slot counter and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
      cnt_r   <= '0;
      digit_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      digit_r <= digit_nxt_s;
    end
  end

  // Next-state: blank guard at slot start, then drive until the slot ends
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CW'(1);
    digit_nxt_s = digit_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == CW'(BLANK_CYCLES - 1)) begin
          state_nxt_s = ST_DRIVE;
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == CW'(REFRESH_DIV - 1)) begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = '0;
          digit_nxt_s = digit_r + 2'd1;
          frame_end_s = (digit_r == 2'd3);
        end else begin
          state_nxt_s = ST_DRIVE;
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
        cnt_nxt_s   = '0;
        digit_nxt_s = 2'd0;
      end
    endcase
  end

  // Pending/active display values; a load landing on the boundary bypasses pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_val_r <= 16'h0000;
      active_dp_r  <= 4'h0;
      pend_val_r   <= 16'h0000;
      pend_dp_r    <= 4'h0;
      pend_flag_r  <= 1'b0;
      load_ack     <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= frame_end_s;
      load_ack   <= 1'b0;
      if (frame_end_s) begin
        if (load) begin
          active_val_r <= value;
          active_dp_r  <= dp_in;
          pend_flag_r  <= 1'b0;
          load_ack     <= 1'b1;
        end else if (pend_flag_r) begin
          active_val_r <= pend_val_r;
          active_dp_r  <= pend_dp_r;
          pend_flag_r  <= 1'b0;
          load_ack     <= 1'b1;
        end
      end else if (load) begin
        pend_val_r  <= value;
        pend_dp_r   <= dp_in;
        pend_flag_r <= 1'b1;
      end
    end
  end

  // Current digit's nibble and whether it and every higher digit are zero
  always_comb begin
    nibble_s     = 4'h0;
    upper_zero_s = 1'b0;
    case (digit_r)
      2'd0: begin
        nibble_s     = active_val_r[3:0];
        upper_zero_s = 1'b0;
      end
      2'd1: begin
        nibble_s     = active_val_r[7:4];
        upper_zero_s = (active_val_r[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s     = active_val_r[11:8];
        upper_zero_s = (active_val_r[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s     = active_val_r[15:12];
        upper_zero_s = (active_val_r[15:12] == 4'h0);
      end
      default: begin
        nibble_s     = 4'h0;
        upper_zero_s = 1'b0;
      end
    endcase
    lit_s = (state_r == ST_DRIVE) && digit_en[digit_r] && !(lz_suppress && upper_zero_s);
  end

  // Registered pin drives; all-high whenever the digit is not lit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (lit_s) begin
      an  <= ~(4'b0001 << digit_r);
      seg <= hex_to_seg(nibble_s);
      dp  <= ~active_dp_r[digit_r];
    end else begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized self-checking bench for seg_scan_controller (REFRESH_DIV=8, BLANK_CYCLES=2).
// Reference model derives slot/digit from the cycle count since reset and tracks active/pending values.
module tb_seg_scan_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_suppress;
  logic        load;
  logic        load_ack;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests;
  int fails;

  seg_scan_controller #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .lz_suppress(lz_suppress), .load(load), .load_ack(load_ack), .frame_tick(frame_tick),
    .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] dec_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: cycles since reset release, plus display values
  int          kc;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_flag;
  logic [13:0] exp_v;
  wire  [13:0] obs_v = {an, seg, dp, load_ack, frame_tick};

  task automatic model_reset();
    kc = 0; m_act = 16'h0; m_pend = 16'h0; m_dp = 4'h0; m_pdp = 4'h0; m_flag = 1'b0;
  endtask

  // predict the outputs of the coming edge from cycle kc, update the model, advance one clock
  task automatic tick();
    int cnt, d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ack, e_tick, bnd;
    cnt = kc % 8; d = (kc / 8) % 4;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (cnt >= 2 && digit_en[d] && !(lz_suppress && d >= 1 && (m_act >> (4 * d)) == 16'h0)) begin
      e_an[d] = 1'b0;
      e_seg = dec_tab[m_act[4*d +: 4]];
      e_dp = ~m_dp[d];
    end
    bnd = ((kc % 32) == 31);
    e_tick = bnd;
    e_ack = bnd && (load || m_flag);
    if (bnd) begin
      if (load) begin m_act = value; m_dp = dp_in; m_flag = 1'b0; end
      else if (m_flag) begin m_act = m_pend; m_dp = m_pdp; m_flag = 1'b0; end
    end else if (load) begin
      m_pend = value; m_pdp = dp_in; m_flag = 1'b1;
    end
    exp_v = {e_an, e_seg, e_dp, e_ack, e_tick};
    @(posedge clk);
    #1;
    kc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    value = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
    lz_suppress = 1'($urandom); load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if (obs_v !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
        fails++; $display("FAIL reset_hold got=%h exp=%h", obs_v, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
      end
    end
    load = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'hF; lz_suppress = 1'b0;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL reset_release got=%h exp=%h", obs_v, exp_v); end
    end
    tests++;
    if (an !== 4'hE) begin fails++; $display("FAIL first_an got=%h exp=e", an); end
  endtask

  task automatic test_scan_order();
    int last_tick, ticks;
    last_tick = -1; ticks = 0;
    value = 16'h1234; dp_in = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    tests++;
    if (obs_v !== exp_v) begin fails++; $display("FAIL scan_load got=%h exp=%h", obs_v, exp_v); end
    for (int i = 0; i < 100; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL scan cyc=%0d got=%h exp=%h", kc, obs_v, exp_v); end
      if (frame_tick === 1'b1) begin
        ticks++;
        if (last_tick >= 0) begin
          tests++;
          if (kc - last_tick !== 32) begin
            fails++; $display("FAIL tick_period got=%0d exp=32", kc - last_tick);
          end
        end
        last_tick = kc;
      end
    end
    tests++;
    if (ticks < 3) begin fails++; $display("FAIL tick_count got=%0d exp>=3", ticks); end
  endtask

  task automatic test_lz();
    lz_suppress = 1'b1;
    for (int p = 0; p < 2; p++) begin
      value = (p == 0) ? 16'h0005 : 16'h0000; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 72; i++) begin
        tick();
        tests++;
        if (obs_v !== exp_v) begin fails++; $display("FAIL lz p=%0d got=%h exp=%h", p, obs_v, exp_v); end
        if (i >= 36 && an !== 4'hF) begin
          tests++;
          if (an !== 4'hE || seg !== ((p == 0) ? 7'h12 : 7'h40)) begin
            fails++; $display("FAIL lz_digit0 p=%0d got=%h/%h", p, an, seg);
          end
        end
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_tear_free();
    int acks;
    acks = 0;
    while (kc % 32 != 10) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL tear_pre got=%h exp=%h", obs_v, exp_v); end
    end
    for (int i = 0; i < 32; i++) begin
      value = (kc % 32 == 10) ? 16'hAAAA : 16'hBBBB;
      load = (kc % 32 == 10) || (kc % 32 == 20);
      tick();
      load = 1'b0;
      if (load_ack === 1'b1) acks++;
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL tear cyc=%0d got=%h exp=%h", kc, obs_v, exp_v); end
    end
    tests++;
    if (acks !== 1) begin fails++; $display("FAIL tear_acks got=%0d exp=1", acks); end
    for (int i = 0; i < 32; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL tear_next got=%h exp=%h", obs_v, exp_v); end
      if (an !== 4'hF && seg !== 7'h03) begin
        fails++; $display("FAIL tear_bbbb got=%h exp=03", seg);
      end
    end
  endtask

  task automatic test_boundary_load();
    while (kc % 32 != 31) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL bnd_pre got=%h exp=%h", obs_v, exp_v); end
    end
    value = 16'($urandom); dp_in = 4'($urandom); load = 1'b1;
    tick();
    load = 1'b0;
    tests++;
    if (load_ack !== 1'b1 || frame_tick !== 1'b1) begin
      fails++; $display("FAIL bnd_ack got=%b%b exp=11", load_ack, frame_tick);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL bnd_post got=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 19) == 0);
      value = 16'($urandom); dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lz_suppress = 1'($urandom);
      tick();
      load = 1'b0;
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL rand cyc=%0d got=%h exp=%h", kc, obs_v, exp_v); end
    end
    digit_en = 4'hF; lz_suppress = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    value = 16'h9876; load = 1'b1;
    tick();
    load = 1'b0;
    while (kc % 32 != 21) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL mid_pre got=%h exp=%h", obs_v, exp_v); end
    end
    tests++;
    if (an !== 4'hB) begin fails++; $display("FAIL mid_drive got=%h exp=b", an); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs_v !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL mid_async got=%h exp=%h", obs_v, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    end
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin fails++; $display("FAIL mid_restart got=%h exp=%h", obs_v, exp_v); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0; digit_en = 4'hF; lz_suppress = 1'b0;
    model_reset();
    exp_v = '0;
    test_reset();
    test_scan_order();
    test_lz();
    test_tear_free();
    test_boundary_load();
    test_random();
    test_reset_mid_drive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
